// File: rtl/br_resolve_ctrl_if.sv
// rtl/br_resolve_ctrl_if.sv - decode/execute/fetch signal bundle for the branch resolution controller
interface br_resolve_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              br_valid;
    logic [5:0]        br_opcode;
    logic [ADDR_W-1:0] br_target;
    logic              flags_valid;
    logic              zeroF;
    logic              negF;
    logic              eqF;
    logic              stall_fe;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              flush;
    logic              busy;
    logic              timeout;
    logic [CNT_W-1:0]  br_total_cnt;
    logic [CNT_W-1:0]  br_taken_cnt;

    modport master (
        output br_valid, br_opcode, br_target, flags_valid, zeroF, negF, eqF,
        input  stall_fe, redirect_valid, redirect_pc, flush, busy, timeout,
               br_total_cnt, br_taken_cnt
    );

    modport slave (
        input  br_valid, br_opcode, br_target, flags_valid, zeroF, negF, eqF,
        output stall_fe, redirect_valid, redirect_pc, flush, busy, timeout,
               br_total_cnt, br_taken_cnt
    );
endinterface

// File: rtl/br_resolve_ctrl.sv
// rtl/br_resolve_ctrl.sv - conditional branch resolution sequencer with redirect, flush and statistics
module br_resolve_ctrl #(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 15,
    parameter int CNT_W        = 16
) (
    input logic           clk,
    input logic           rst,
    br_resolve_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    localparam logic [5:0] OP_BEQ  = 6'b001110;
    localparam logic [5:0] OP_BNEQ = 6'b001111;
    localparam logic [5:0] OP_BLEZ = 6'b010000;
    localparam logic [5:0] OP_BGTZ = 6'b010001;

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int FL_W   = $clog2(FLUSH_CYCLES + 1);

    logic [1:0]        state;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] target_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [FL_W-1:0]   fl_cnt;
    logic              timeout_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  taken_q;
    logic              is_branch;
    logic              cond_taken;

    always_comb begin
        is_branch = (bus.br_opcode == OP_BEQ)  || (bus.br_opcode == OP_BNEQ) ||
                    (bus.br_opcode == OP_BLEZ) || (bus.br_opcode == OP_BGTZ);
    end

    // Only the latched opcode selects the condition; flags feed state, never outputs.
    always_comb begin
        cond_taken = 1'b0;
        case (op_q)
            OP_BEQ:  cond_taken = bus.eqF;
            OP_BNEQ: cond_taken = ~bus.eqF;
            OP_BLEZ: cond_taken = bus.negF | bus.zeroF;
            OP_BGTZ: cond_taken = ~bus.negF & ~bus.zeroF;
            default: cond_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            target_q  <= '0;
            wait_cnt  <= '0;
            fl_cnt    <= '0;
            timeout_q <= 1'b0;
            total_q   <= '0;
            taken_q   <= '0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.br_valid && is_branch) begin
                        op_q     <= bus.br_opcode;
                        target_q <= bus.br_target;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.flags_valid) begin
                        if (total_q != {CNT_W{1'b1}}) total_q <= total_q + 1'b1;
                        if (cond_taken) begin
                            if (taken_q != {CNT_W{1'b1}}) taken_q <= taken_q + 1'b1;
                            state <= ST_REDIRECT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    // The redirect cycle already counts as the first flush cycle.
                    if (FLUSH_CYCLES > 1) begin
                        fl_cnt <= FL_W'(FLUSH_CYCLES - 1);
                        state  <= ST_FLUSH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    fl_cnt <= fl_cnt - 1'b1;
                    if (fl_cnt <= FL_W'(1)) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.stall_fe       = (state != ST_IDLE);
    assign bus.busy           = (state != ST_IDLE);
    assign bus.redirect_valid = (state == ST_REDIRECT);
    assign bus.redirect_pc    = (state == ST_REDIRECT) ? target_q : '0;
    assign bus.flush          = (state == ST_REDIRECT) || (state == ST_FLUSH);
    assign bus.timeout        = timeout_q;
    assign bus.br_total_cnt   = total_q;
    assign bus.br_taken_cnt   = taken_q;
endmodule

// File: tb/tb_br_resolve_ctrl.sv
// tb/tb_br_resolve_ctrl.sv - directed self-checking bench for br_resolve_ctrl
module tb_br_resolve_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    br_resolve_ctrl_if #(.ADDR_W(32), .CNT_W(4)) bus ();

    br_resolve_ctrl #(
        .ADDR_W(32), .FLUSH_CYCLES(2), .MAX_WAIT(15), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [5:0] op, input logic [31:0] tgt);
        bus.br_valid  = 1'b1;
        bus.br_opcode = op;
        bus.br_target = tgt;
    endtask

    task automatic flags(input logic v, input logic z, input logic n, input logic e);
        bus.flags_valid = v;
        bus.zeroF       = z;
        bus.negF        = n;
        bus.eqF         = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.br_valid = 1'b0; bus.br_opcode = '0; bus.br_target = '0;
        flags(0, 0, 0, 0);
        step(); step();
        check("rst_busy", bus.busy, 0);
        check("rst_stall", bus.stall_fe, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_redir", bus.redirect_valid, 0);
        check("rst_total", bus.br_total_cnt, 0);
        rst = 1'b0;
        step();

        // BEQ taken
        present(6'b001110, 32'h40);
        step();
        bus.br_valid = 1'b0;
        check("beq_busy", bus.busy, 1);
        check("beq_stall", bus.stall_fe, 1);
        check("beq_noflush_wait", bus.flush, 0);
        step();
        flags(1, 0, 0, 1);
        step();
        flags(0, 0, 0, 0);
        check("beq_redir", bus.redirect_valid, 1);
        check("beq_pc", bus.redirect_pc, 32'h40);
        check("beq_flush_r", bus.flush, 1);
        check("beq_total", bus.br_total_cnt, 1);
        check("beq_taken", bus.br_taken_cnt, 1);
        step();
        check("beq_redir_off", bus.redirect_valid, 0);
        check("beq_flush_f", bus.flush, 1);
        check("beq_busy_f", bus.busy, 1);
        step();
        check("beq_flush_done", bus.flush, 0);
        check("beq_idle", bus.busy, 0);
        check("beq_stall_done", bus.stall_fe, 0);

        // BGTZ not taken
        present(6'b010001, 32'h80);
        step();
        bus.br_valid = 1'b0;
        flags(1, 1, 0, 0);
        step();
        flags(0, 0, 0, 0);
        check("bgtz_idle", bus.busy, 0);
        check("bgtz_noredir", bus.redirect_valid, 0);
        check("bgtz_noflush", bus.flush, 0);
        check("bgtz_total", bus.br_total_cnt, 2);
        check("bgtz_taken", bus.br_taken_cnt, 1);

        // non-branch opcode
        present(6'b000011, 32'h123);
        step();
        bus.br_valid = 1'b0;
        check("nb_busy", bus.busy, 0);
        check("nb_stall", bus.stall_fe, 0);
        step();
        check("nb_busy2", bus.busy, 0);
        check("nb_total", bus.br_total_cnt, 2);

        // BNEQ timeout after 15 WAIT cycles
        present(6'b001111, 32'h200);
        step();
        bus.br_valid = 1'b0;
        for (int i = 1; i < 15; i++) begin
            step();
            check("to_wait_busy", bus.busy, 1);
            check("to_wait_pulse", bus.timeout, 0);
        end
        step();
        check("to_pulse", bus.timeout, 1);
        check("to_idle", bus.busy, 0);
        check("to_total", bus.br_total_cnt, 2);
        check("to_taken", bus.br_taken_cnt, 1);
        step();
        check("to_pulse_end", bus.timeout, 0);

        // BNEQ with flags on the 15th WAIT cycle: flags win
        present(6'b001111, 32'h300);
        step();
        bus.br_valid = 1'b0;
        for (int i = 1; i < 15; i++) step();
        check("lim_still_wait", bus.busy, 1);
        flags(1, 0, 0, 0);
        step();
        flags(0, 0, 0, 0);
        check("lim_no_timeout", bus.timeout, 0);
        check("lim_redir", bus.redirect_valid, 1);
        check("lim_pc", bus.redirect_pc, 32'h300);
        check("lim_total", bus.br_total_cnt, 3);
        check("lim_taken", bus.br_taken_cnt, 2);
        step(); step();
        check("lim_idle", bus.busy, 0);

        // async reset during FLUSH
        present(6'b001110, 32'h44);
        step();
        bus.br_valid = 1'b0;
        flags(1, 0, 0, 1);
        step();
        flags(0, 0, 0, 0);
        step();
        check("mrst_in_flush", bus.flush, 1);
        rst = 1'b1;
        #1;
        check("mrst_flush", bus.flush, 0);
        check("mrst_busy", bus.busy, 0);
        check("mrst_stall", bus.stall_fe, 0);
        check("mrst_pc", bus.redirect_pc, 0);
        check("mrst_total", bus.br_total_cnt, 0);
        check("mrst_taken", bus.br_taken_cnt, 0);
        step();
        rst = 1'b0;
        step();
        check("mrst_idle", bus.busy, 0);

        // 17 taken BLEZ with 4-bit counters
        for (int i = 1; i <= 17; i++) begin
            present(6'b010000, 32'h1000 + 32'(i));
            step();
            bus.br_valid = 1'b0;
            flags(1, 0, 1, 0);
            step();
            flags(0, 0, 0, 0);
            check("sat_redir", bus.redirect_valid, 1);
            check("sat_total", bus.br_total_cnt, (i > 15) ? 15 : i);
            check("sat_taken", bus.br_taken_cnt, (i > 15) ? 15 : i);
            step(); step();
        end

        // second br_valid during WAIT must not replace the captured branch
        present(6'b001110, 32'h100);
        step();
        present(6'b010001, 32'h2000);
        step();
        flags(1, 0, 1, 1);
        step();
        flags(0, 0, 0, 0);
        bus.br_valid = 1'b0;
        check("busy_ign_redir", bus.redirect_valid, 1);
        check("busy_ign_pc", bus.redirect_pc, 32'h100);
        check("busy_ign_total", bus.br_total_cnt, 15);
        step(); step();
        check("busy_ign_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
